// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB power-up configuration sequencer.
package sccb_cfg_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  localparam logic [ENTRY_W-1:0] CFG_END        = 16'hFFFF;
  localparam logic [ADDR_W-1:0]  CFG_DELAY_ADDR = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    POWERUP_WAIT,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    DELAY,
    DONE,
    ERROR
  } cfg_state_t;

endpackage

// File: rtl/cam_config_rom.sv
// Camera sensor register table, {addr, data} per entry, one-cycle read latency.
// Further sensor writes (e.g. 0x40/0xD0 for RGB565) go before the end marker.
module cam_config_rom
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned AddrWidth = 6
) (
  input  logic                 clk,
  input  logic [AddrWidth-1:0] index,
  output logic [ENTRY_W-1:0]   entry
);

  always_ff @(posedge clk) begin
    case (index)
      AddrWidth'(0): entry <= 16'h1280;  // COM7 soft reset
      AddrWidth'(1): entry <= 16'hFF0A;  // settle 10 ms after soft reset
      AddrWidth'(2): entry <= 16'h1204;  // COM7 RGB output
      default:       entry <= CFG_END;
    endcase
  end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the camera ROM table and issues register writes to the SCCB master.
// Optional macro SCCB_CFG_RETRY_EN: retry an unaccepted write up to 3 times.
module sccb_config_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned PowerUpDelayMs = 2,
  parameter int unsigned RomAddrWidth   = 6,
  parameter int unsigned AcceptTimeout  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_start,
  output logic [ADDR_W-1:0]       o_sccb_addr,
  output logic [DATA_W-1:0]       o_sccb_data,
  output logic                    o_sccb_ready,
  input  logic                    i_sccb_busy,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
`ifdef SCCB_CFG_RETRY_EN
  output logic [1:0]              o_retry_cnt,
`endif
  output logic [RomAddrWidth-1:0] o_index
);

  localparam int unsigned TICKS = (ClockFrequency / 1000 > 0) ? ClockFrequency / 1000 : 1;
  localparam int unsigned CW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [RomAddrWidth-1:0] IDX_LAST = '1;

  cfg_state_t         state;
  logic [CW-1:0]      ms_cnt;
  logic               tick;
  logic [15:0]        ms_left;
  logic [15:0]        wait_cnt;
  logic [ENTRY_W-1:0] entry;
  logic [ADDR_W-1:0]  e_addr;
  logic [DATA_W-1:0]  e_data;
  logic               at_last;

  assign tick            = (ms_cnt == CW'(TICKS - 1));
  assign {e_addr, e_data} = entry;
  assign at_last         = (o_index == IDX_LAST);

  cam_config_rom #(.AddrWidth(RomAddrWidth)) u_rom (
    .clk   (CLK),
    .index (o_index),
    .entry (entry)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= POWERUP_WAIT;
      ms_cnt       <= '0;
      ms_left      <= '0;
      wait_cnt     <= '0;
      o_sccb_addr  <= '0;
      o_sccb_data  <= '0;
      o_sccb_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_index      <= '0;
`ifdef SCCB_CFG_RETRY_EN
      o_retry_cnt  <= '0;
`endif
    end else begin
      ms_cnt       <= tick ? '0 : ms_cnt + 1'b1;
      o_sccb_ready <= 1'b0;
      o_busy       <= 1'b1;
      case (state)
        IDLE: begin
          o_busy  <= 1'b0;
          state   <= POWERUP_WAIT;
          ms_cnt  <= '0;
          ms_left <= '0;
        end
        POWERUP_WAIT: begin
          if (PowerUpDelayMs == 0 || (tick && 32'(ms_left) + 32'd1 >= PowerUpDelayMs)) begin
            state   <= FETCH;
            o_index <= '0;
          end else if (tick) begin
            ms_left <= ms_left + 1'b1;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (entry == CFG_END) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (e_addr == CFG_DELAY_ADDR) begin
            if (e_data == '0) begin
              if (at_last) begin
                state  <= DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end else begin
                o_index <= o_index + 1'b1;
                state   <= FETCH;
              end
            end else begin
              state   <= DELAY;
              ms_left <= 16'(e_data);
              ms_cnt  <= '0;
            end
          end else begin
            o_sccb_addr <= e_addr;
            o_sccb_data <= e_data;
`ifdef SCCB_CFG_RETRY_EN
            o_retry_cnt <= '0;
`endif
            state       <= ISSUE;
          end
        end
        // ready is raised and dropped while still in ISSUE, so the request never leaks out of it
        ISSUE: begin
          if (o_sccb_ready) begin
            state    <= WAIT_ACCEPT;
            wait_cnt <= '0;
          end else if (!i_sccb_busy) begin
            o_sccb_ready <= 1'b1;
          end
        end
        WAIT_ACCEPT: begin
          if (i_sccb_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == 16'(AcceptTimeout - 1)) begin
`ifdef SCCB_CFG_RETRY_EN
            if (o_retry_cnt != 2'd3) begin
              o_retry_cnt <= o_retry_cnt + 1'b1;
              state       <= ISSUE;
            end else begin
`else
            begin
`endif
              state   <= ERROR;
              o_busy  <= 1'b0;
              o_error <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!i_sccb_busy) begin
            if (at_last) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              o_index <= o_index + 1'b1;
              state   <= FETCH;
            end
          end
        end
        DELAY: begin
          if (tick) begin
            if (ms_left == 16'd1) begin
              if (at_last) begin
                state  <= DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end else begin
                o_index <= o_index + 1'b1;
                state   <= FETCH;
              end
            end else begin
              ms_left <= ms_left - 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          if (i_start) begin
            o_done  <= 1'b0;
            o_error <= 1'b0;
            o_index <= '0;
            state   <= FETCH;
          end else begin
            o_busy <= 1'b0;
          end
        end
        default: state <= POWERUP_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Self-checking bench for sccb_config_sequencer with a stub SCCB master.
// Builds with or without SCCB_CFG_RETRY_EN.
module tb_sccb_config_sequencer;

  localparam int CLK_HZ = 10_000;
  localparam int TICKS  = CLK_HZ / 1000;
  localparam int PWR_MS = 2;
  localparam int AW     = 6;
  localparam int TMO    = 16;
`ifdef SCCB_CFG_RETRY_EN
  localparam int TRIES  = 4;
`else
  localparam int TRIES  = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          i_start = 1'b0;
  logic          stub_busy = 1'b0;
  logic          force_busy = 1'b0;
  logic          sccb_busy;
  logic [7:0]    sccb_addr, sccb_data;
  logic          sccb_ready, busy, done, error;
  logic [AW-1:0] index;
`ifdef SCCB_CFG_RETRY_EN
  logic [1:0]    retry_cnt;
`endif

  assign sccb_busy = stub_busy | force_busy;

  sccb_config_sequencer #(
    .ClockFrequency (CLK_HZ),
    .PowerUpDelayMs (PWR_MS),
    .RomAddrWidth   (AW),
    .AcceptTimeout  (TMO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .i_start      (i_start),
    .o_sccb_addr  (sccb_addr),
    .o_sccb_data  (sccb_data),
    .o_sccb_ready (sccb_ready),
    .i_sccb_busy  (sccb_busy),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
`ifdef SCCB_CFG_RETRY_EN
    .o_retry_cnt  (retry_cnt),
`endif
    .o_index      (index)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;

  typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } pulse_t;
  pulse_t rq[$];
  int     fall_q[$];

  // reference table and expectations derived from it
  logic [15:0] tab [4] = '{16'h1280, 16'hFF0A, 16'h1204, 16'hFFFF};
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_d[$];
  int          exp_gap[$];
  int          exp_end;

  bit stub_en = 1'b1;
  int stub_lat = 2;
  int stub_dur = 4;
  int st = 0;
  int sc = 0;

  // stub master: raises busy stub_lat cycles after a request, holds it stub_dur cycles
  initial forever begin
    @(posedge CLK); #1;
    if (!RST) begin
      st = 0;
      stub_busy = 1'b0;
    end else begin
      case (st)
        0: if (sccb_ready && stub_en) begin st = 1; sc = stub_lat; end
        1: begin sc--; if (sc <= 0) begin stub_busy = 1'b1; st = 2; sc = stub_dur; end end
        2: begin sc--; if (sc <= 0) begin stub_busy = 1'b0; st = 0; end end
        default: st = 0;
      endcase
    end
  end

  logic       m_pr = 1'b0, m_out = 1'b0, m_seen = 1'b0;
  logic [7:0] m_a = '0, m_d = '0;

  // monitor: records requests and busy falls, counts protocol violations
  initial forever begin
    @(posedge CLK); #2;
    cyc++;
    if (!RST) begin
      m_out = 1'b0;
      m_pr  = 1'b0;
    end else begin
      if (sccb_ready) begin
        if (m_pr || (m_out && m_seen)) viol++;
        rq.push_back('{cyc, sccb_addr, sccb_data});
        m_out = 1'b1; m_seen = 1'b0; m_a = sccb_addr; m_d = sccb_data;
      end else if (m_out) begin
        if (sccb_addr !== m_a || sccb_data !== m_d) viol++;
        if (sccb_busy) m_seen = 1'b1;
        else if (m_seen) begin m_out = 1'b0; fall_q.push_back(cyc); end
        if (error) m_out = 1'b0;
      end
      m_pr = sccb_ready;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tg);
    check({tg, "_busy"},  32'(busy), 32'd0);
    check({tg, "_done"},  32'(done), 32'd0);
    check({tg, "_error"}, 32'(error), 32'd0);
    check({tg, "_ready"}, 32'(sccb_ready), 32'd0);
    check({tg, "_index"}, 32'(index), 32'd0);
    check({tg, "_addr"},  32'(sccb_addr), 32'd0);
    check({tg, "_data"},  32'(sccb_data), 32'd0);
  endtask

  task automatic restart(input string tg, output int t0);
    rq.delete();
    fall_q.delete();
    i_start = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    i_start = 1'b0;
    check({tg, "_done_clr"},  32'(done), 32'd0);
    check({tg, "_error_clr"}, 32'(error), 32'd0);
    check({tg, "_busy_set"},  32'(busy), 32'd1);
  endtask

  // mode 0: power-up delay expected, 1: immediate start, 2: first request after t_ref
  task automatic check_run(input string tg, input int t_ref, input int mode);
    for (int i = 0; i < 3000 && !done; i++) @(negedge CLK);
    check({tg, "_done"},  32'(done), 32'd1);
    check({tg, "_busy"},  32'(busy), 32'd0);
    check({tg, "_error"}, 32'(error), 32'd0);
    check({tg, "_index"}, 32'(index), 32'(exp_end));
    check({tg, "_nreq"},  32'(rq.size()), 32'(exp_a.size()));
    for (int k = 0; k < exp_a.size(); k++) begin
      if (k < rq.size()) begin
        check({tg, "_addr"}, 32'(rq[k].a), 32'(exp_a[k]));
        check({tg, "_data"}, 32'(rq[k].d), 32'(exp_d[k]));
        if (k > 0 && k - 1 < fall_q.size())
          check({tg, "_gap"}, 32'(rq[k].cyc - fall_q[k-1] >= exp_gap[k] * TICKS), 32'd1);
      end
    end
    if (rq.size() > 0) begin
      if (mode == 0)      check({tg, "_pwr_wait"},  32'(rq[0].cyc - t_ref >= PWR_MS * TICKS), 32'd1);
      else if (mode == 1) check({tg, "_no_pwr"},    32'(rq[0].cyc - t_ref < TICKS), 32'd1);
      else                check({tg, "_held_off"},  32'(rq[0].cyc > t_ref), 32'd1);
    end
    check({tg, "_protocol"}, 32'(viol), 32'd0);
  endtask

  int t0;
  int t_rel;
  int errc;
  int pend;

  initial begin
    pend = 0;
    exp_end = -1;
    foreach (tab[i]) begin
      if (exp_end < 0) begin
        if (tab[i] == 16'hFFFF) exp_end = i;
        else if (tab[i][15:8] == 8'hFF) pend += int'(tab[i][7:0]);
        else begin
          exp_a.push_back(tab[i][15:8]);
          exp_d.push_back(tab[i][7:0]);
          exp_gap.push_back(pend);
          pend = 0;
        end
      end
    end

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_zero("reset");

    // power-up run followed by randomized replays
    for (int r = 0; r < 3; r++) begin
      stub_lat = (r == 0) ? 2 : int'($urandom_range(1, 4));
      stub_dur = (r == 0) ? 100 : int'($urandom_range(1, 12));
      if (r == 0) begin
        rq.delete();
        fall_q.delete();
        RST = 1'b1;
        t0 = cyc;
        check_run("pwrup", t0, 0);
      end else begin
        restart("replay", t0);
        check_run("replay", t0, 1);
      end
    end

    // i_start while a write is in flight is ignored
    stub_lat = 1;
    stub_dur = 10;
    restart("ign", t0);
    for (int i = 0; i < 200 && !stub_busy; i++) @(negedge CLK);
    check("ign_reach_wd", 32'(stub_busy), 32'd1);
    i_start = 1'b1;
    @(negedge CLK);
    i_start = 1'b0;
    check_run("ign", t0, 1);

    // reset pulse during WAIT_DONE
    restart("rstwd", t0);
    for (int i = 0; i < 200 && !stub_busy; i++) @(negedge CLK);
    check("rstwd_reach_wd", 32'(stub_busy), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    check_zero("rstwd");
    rq.delete();
    fall_q.delete();
    RST = 1'b1;
    t0 = cyc;
    check_run("rstwd", t0, 0);

    // master already busy when the first write is ready to go
    stub_lat = int'($urandom_range(1, 4));
    stub_dur = int'($urandom_range(1, 12));
    force_busy = 1'b1;
    restart("prebusy", t0);
    repeat (30) @(negedge CLK);
    check("prebusy_noreq", 32'(rq.size()), 32'd0);
    check("prebusy_addr",  32'(sccb_addr), 32'(exp_a[0]));
    check("prebusy_data",  32'(sccb_data), 32'(exp_d[0]));
    check("prebusy_busy",  32'(busy), 32'd1);
    force_busy = 1'b0;
    t_rel = cyc;
    check_run("prebusy", t_rel, 2);

    // master never accepts
    stub_en = 1'b0;
    restart("tmo", t0);
    for (int i = 0; i < 500 && !error; i++) @(negedge CLK);
    errc = cyc;
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_index", 32'(index), 32'd0);
    check("tmo_busy",  32'(busy), 32'd0);
    check("tmo_done",  32'(done), 32'd0);
    check("tmo_nreq",  32'(rq.size()), 32'(TRIES));
    if (rq.size() > 0) begin
      check("tmo_lo", 32'(errc - rq[rq.size()-1].cyc >= TMO), 32'd1);
      check("tmo_hi", 32'(errc - rq[rq.size()-1].cyc <= TMO + 2), 32'd1);
      foreach (rq[k]) check("tmo_addr", 32'({rq[k].a, rq[k].d}), 32'({exp_a[0], exp_d[0]}));
    end
`ifdef SCCB_CFG_RETRY_EN
    check("tmo_retry_cnt", 32'(retry_cnt), 32'd3);
`endif
    repeat (5) @(negedge CLK);
    check("tmo_hold", 32'(error), 32'd1);
    stub_en = 1'b1;
    restart("after_err", t0);
    check_run("after_err", t0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
